alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit calculator ALU. Accepts operation requests (A, B, opcode) from two independent requesters over valid/ready, drives the combinational ALU from registered operands, and returns registered result/overflow with the requester ID over a valid/ready response channel. It also screens out the unimplemented opcodes 1101–1111 and modulo-by-zero, so no X reaches downstream logic.

## Interface
- No parameters. Data width is fixed at 4 bits and opcode width at 4 bits, matching the ALU.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  4  operands
- req0_op / req1_op  in  4  ALU opcode
- req0_acc / req1_acc  in  1  use accumulator as A (ignored unless ALU_ARB_ACC_EN)
- alu_a, alu_b  out  4  operands to ALU
- alu_op  out  4  opcode to ALU
- alu_reset  out  1  ALU reset; equals reset
- alu_result  in  4  ALU Result
- alu_overflow  in  1  ALU Overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester ID (0/1)
- rsp_result  out  4  result
- rsp_overflow  out  1  overflow flag
- rsp_illegal  out  1  opcode 1101–1111, or 1001 (modulo) with B=0

## Operation
- FSM states are IDLE, EXEC and RESP. Reset forces IDLE.
- **Reset values:** req*_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_illegal=0, alu_a/alu_b/alu_op=0, rr pointer=0 (requester 0 has priority), accumulator=0.
- **IDLE**
  - req*_ready is combinational. It is high only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - Grant rule: with a single valid, that requester wins. With both valid, the requester named by the rr pointer wins.
  - On handshake, latch a, b, op and acc, record the ID, and go to EXEC.
- **EXEC** (exactly 1 cycle)
  - Drive alu_a, alu_b and alu_op from the latched registers.
  - Capture into the rsp_* registers, then go to RESP:
    - Illegal opcode (1101–1111): rsp_result=0, rsp_overflow=0, rsp_illegal=1. The ALU output is ignored.
    - Opcode 1001 with B=0: rsp_result=0, rsp_overflow=1, rsp_illegal=1.
    - Otherwise: rsp_result=alu_result, rsp_overflow=alu_overflow, rsp_illegal=0.
- **RESP**
  - rsp_valid=1, and all rsp_* fields are held stable until rsp_ready.
  - On rsp_valid && rsp_ready:
    - rr pointer becomes ~rsp_id, so the other requester gets priority.
    - The accumulator loads rsp_result (macro builds only).
    - Go to IDLE.
- No request is accepted while in EXEC or RESP; both ready outputs are 0.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- Requester-side rule: a requester must hold valid and its fields stable until ready. The arbiter does not check this.

## Timing
- The request handshake in cycle N leads to EXEC in N+1 and rsp_valid=1 in N+2.
- Minimum issue interval is 3 cycles (back-to-back with rsp_ready tied high).
- The response handshake and the next request handshake never occur in the same cycle. The next grant happens in the cycle after the response handshake.
- Reset asserted in any state takes effect at the next edge:
  - The in-flight operation is discarded and no response is issued.
  - All outputs return to their reset values, rr is cleared to 0, and the accumulator is cleared to 0.
- rsp_ready held low stalls in RESP indefinitely and blocks both requesters (no starvation beyond that stall).

## Configuration
- Macro: `ALU_ARB_ACC_EN`.
- **Defined:**
  - A 4-bit accumulator register exists.
  - If the latched acc bit is 1, EXEC drives alu_a from the accumulator instead of the latched A. The acc bit is latched with the request.
  - The accumulator updates on every response handshake, including illegal responses, which write 0.
- **Undefined:**
  - No accumulator register exists.
  - req*_acc is ignored and alu_a always equals the latched A.

## Test plan
- **Reset:** assert reset with both valids high -> all outputs at reset values, both readys 0. Deassert -> req0 granted first.
- **Add:** req0 sends A=7, B=5, op=0011 with rsp_ready=1 -> rsp_valid 2 cycles after the handshake, rsp_id=0, result=12, overflow=0, illegal=0.
- **Round-robin:** both valid continuously, op=0010 -> grants alternate 0,1,0,1 and responses alternate IDs. req1 alone with A=3, B=9, op=0010 -> result=10, overflow=1.
- **Screening:**
  - op=1110 -> result=0, illegal=1, overflow=0.
  - op=1001 with A=6, B=0 -> result=0, overflow=1, illegal=1.
  - op=1001 with A=7, B=3 -> result=1, illegal=0.
- **Backpressure and reset mid-operation:**
  - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readys 0.
  - Assert reset during EXEC -> no response is issued and rr=0.
- **Accumulator (`ALU_ARB_ACC_EN`):** A=4, B=4, op=0011, then acc=1, B=2, op=0011 -> results 8 then 10. Without the macro, the same stimulus with A=1 in the second request -> result 3.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared 4-bit
//   calculator ALU. A granted request is latched, presented to the
//   combinational ALU for one EXEC cycle, and the screened result is returned
//   over a valid/ready response channel. Unimplemented opcodes (1101-1111) and
//   modulo-by-zero (1001 with B=0) are replaced by fixed values so no X from
//   the ALU reaches downstream logic.
//
//   Optional feature macro: ALU_ARB_ACC_EN
//     Defined   : a 4-bit accumulator can replace operand A (req*_acc=1); it
//                 loads rsp_result on every response handshake.
//     Undefined : no accumulator; req*_acc is ignored.
//
//   Ports
//     clk, reset                      clock, synchronous active-high reset
//     req{0,1}_valid/ready            request handshake (ready is combinational)
//     req{0,1}_a/_b/_op/_acc          request operands, opcode, use-accumulator
//     alu_a/alu_b/alu_op/alu_reset    to ALU (operands registered)
//     alu_result/alu_overflow         from ALU
//     rsp_valid/rsp_ready             response handshake
//     rsp_id/result/overflow/illegal  registered response fields
module alu_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req0_acc,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  input  logic       req1_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_reset,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic       rsp_overflow,
  output logic       rsp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       id_q, id_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [3:0] rsp_result_q, rsp_result_d;
  logic       rsp_overflow_q, rsp_overflow_d;
  logic       rsp_illegal_q, rsp_illegal_d;

  logic       grant1;
  logic       req_hs;
  logic       rsp_hs;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [3:0] sel_op;
  logic       op_unimpl;
  logic       mod_zero;

`ifdef ALU_ARB_ACC_EN
  logic [3:0] acc_q, acc_d;
  logic       sel_acc;
`else
  logic       unused_acc;
  assign unused_acc = req0_acc ^ req1_acc;
`endif

  // Requester 1 wins when alone, or when both are valid and rr points at it.
  assign grant1 = req1_valid && (!req0_valid || rr_q);
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;
  assign sel_op = grant1 ? req1_op : req0_op;
`ifdef ALU_ARB_ACC_EN
  assign sel_acc = grant1 ? req1_acc : req0_acc;
`endif

  assign op_unimpl = (alu_op_q >= 4'd13);
  assign mod_zero  = (alu_op_q == 4'b1001) && (alu_b_q == 4'd0);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------- output comb
  // Ready is gated by reset so no handshake can be seen while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = (state_q == RESP);
    if (state_q == IDLE && !reset) begin
      req0_ready = req0_valid && !grant1;
      req1_ready = grant1;
    end
  end

  assign req_hs = req0_ready | req1_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  // ------------------------------------------------------------ datapath comb
  // Operands are loaded straight into the ALU-facing registers at the request
  // handshake; the accumulator cannot change between handshake and EXEC, so
  // the substitution can be made at load time and the ALU inputs stay frozen
  // outside EXEC.
  always_comb begin
    rr_d           = rr_q;
    id_d           = id_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;
`ifdef ALU_ARB_ACC_EN
    acc_d          = acc_q;
`endif

    if (req_hs) begin
      id_d     = grant1;
`ifdef ALU_ARB_ACC_EN
      alu_a_d  = sel_acc ? acc_q : sel_a;
`else
      alu_a_d  = sel_a;
`endif
      alu_b_d  = sel_b;
      alu_op_d = sel_op;
    end

    if (state_q == EXEC) begin
      if (op_unimpl) begin
        rsp_result_d   = 4'd0;
        rsp_overflow_d = 1'b0;
        rsp_illegal_d  = 1'b1;
      end else if (mod_zero) begin
        rsp_result_d   = 4'd0;
        rsp_overflow_d = 1'b1;
        rsp_illegal_d  = 1'b1;
      end else begin
        rsp_result_d   = alu_result;
        rsp_overflow_d = alu_overflow;
        rsp_illegal_d  = 1'b0;
      end
    end

    if (rsp_hs) begin
      rr_d  = ~id_q;
`ifdef ALU_ARB_ACC_EN
      acc_d = rsp_result_q;
`endif
    end
  end

  // ------------------------------------------------------------ datapath regs
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q           <= 1'b0;
      id_q           <= 1'b0;
      alu_a_q        <= 4'd0;
      alu_b_q        <= 4'd0;
      alu_op_q       <= 4'd0;
      rsp_result_q   <= 4'd0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
`ifdef ALU_ARB_ACC_EN
      acc_q          <= 4'd0;
`endif
    end else begin
      rr_q           <= rr_d;
      id_q           <= id_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
`ifdef ALU_ARB_ACC_EN
      acc_q          <= acc_d;
`endif
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_reset    = reset;
  assign rsp_id       = id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter. A small reference ALU drives alu_result/overflow.
//   A transaction-level model (busy flag + phase age, rr bit, accumulator and
//   the expected response computed from the screening rules) is compared with
//   the DUT on every falling edge; directed scenarios add literal checks.
module tb_alu_arbiter;

`ifdef ALU_ARB_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_acc;
  logic [3:0] req0_a, req0_b, req0_op;
  logic       req1_valid, req1_ready, req1_acc;
  logic [3:0] req1_a, req1_b, req1_op;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_reset;
  logic [3:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_illegal;
  logic [3:0] rsp_result;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_acc(req0_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_acc(req1_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_reset(alu_reset),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal)
  );

  // Reference ALU {overflow, result}. Unimplemented opcodes and mod-by-zero
  // return distinctive junk so that missing screening is visible.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, b, op);
    logic [4:0] s;
    case (op)
      4'd0:  s = {1'b0, a & b};
      4'd1:  s = {1'b0, a | b};
      4'd2:  s = {(a < b), a - b};
      4'd3:  s = {1'b0, a} + {1'b0, b};
      4'd4:  s = {1'b0, a ^ b};
      4'd9:  s = (b == 4'd0) ? {1'b0, 4'hF} : {1'b0, a % b};
      4'd13, 4'd14, 4'd15: s = {1'b1, 4'hA};
      default: s = {1'b0, ~a};
    endcase
    return s;
  endfunction

  assign {alu_overflow, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  bit         m_on = 1'b0;
  bit         m_busy, m_rr, m_id;
  int         m_age;
  logic [3:0] m_a, m_b, m_op, m_acc;
  logic [3:0] e_res;
  bit         e_ovf, e_ill;
  bit         e_r0, e_r1;
  logic [4:0] m_alu;

  always @(negedge clk) begin
    e_r0 = !reset && !m_busy && req0_valid && (!req1_valid || !m_rr);
    e_r1 = !reset && !m_busy && req1_valid && (!req0_valid || m_rr);
    if (m_on) begin
      chk("m_req0_ready", req0_ready, e_r0);
      chk("m_req1_ready", req1_ready, e_r1);
      chk("m_rsp_valid",  rsp_valid,  m_busy && m_age == 2);
      chk("m_alu_a",      alu_a,      m_a);
      chk("m_alu_b",      alu_b,      m_b);
      chk("m_alu_op",     alu_op,     m_op);
      chk("m_alu_reset",  alu_reset,  reset);
      if (m_busy && m_age == 2) begin
        chk("m_rsp_id",       rsp_id,       m_id);
        chk("m_rsp_result",   rsp_result,   e_res);
        chk("m_rsp_overflow", rsp_overflow, e_ovf);
        chk("m_rsp_illegal",  rsp_illegal,  e_ill);
      end
    end
    // advance to the state after the coming rising edge
    if (reset) begin
      m_on = 1'b1; m_busy = 1'b0; m_age = 0; m_rr = 1'b0; m_id = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_acc = '0;
    end else if (m_on && !m_busy) begin
      if (e_r0 || e_r1) begin
        m_id = e_r1;
        m_a  = e_r1 ? req1_a : req0_a;
        if (ACC && (e_r1 ? req1_acc : req0_acc)) m_a = m_acc;
        m_b  = e_r1 ? req1_b  : req0_b;
        m_op = e_r1 ? req1_op : req0_op;
        if (m_op >= 4'd13) begin
          e_res = 4'd0; e_ovf = 1'b0; e_ill = 1'b1;
        end else if (m_op == 4'd9 && m_b == 4'd0) begin
          e_res = 4'd0; e_ovf = 1'b1; e_ill = 1'b1;
        end else begin
          m_alu = ref_alu(m_a, m_b, m_op);
          e_res = m_alu[3:0]; e_ovf = m_alu[4]; e_ill = 1'b0;
        end
        m_busy = 1'b1; m_age = 1;
      end
    end else if (m_on && m_age == 1) begin
      m_age = 2;
    end else if (m_on && rsp_ready) begin
      m_rr = ~m_id; m_acc = e_res; m_busy = 1'b0; m_age = 0;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic drain();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  // One request from requester `id`; checks handshake-to-response latency and
  // the response fields against hand-computed literals. Returns at the
  // falling edge where rsp_valid is seen.
  task automatic send(input string nm, input bit id, input logic [3:0] a, b, op,
                      input bit acc, input int x_res, x_ovf, x_ill);
    int n;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_acc = acc;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_acc = acc;
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? req1_ready : req0_ready) && n < 20);
    if (n >= 20) chk({nm, "_grant_timeout"}, 0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk({nm, "_latency"},  n, 2);
    chk({nm, "_id"},       rsp_id, id);
    chk({nm, "_result"},   rsp_result, x_res);
    chk({nm, "_overflow"}, rsp_overflow, x_ovf);
    chk({nm, "_illegal"},  rsp_illegal, x_ill);
  endtask

  int gid[$];
  int gcyc[$];
  int rids[$];

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd1; req0_op = 4'd2; req0_acc = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3; req1_op = 4'd2; req1_acc = 1'b0;

    // Reset with both valids high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid",  rsp_valid, 0);
    chk("rst_rsp_id",     rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_ovf",    rsp_overflow, 0);
    chk("rst_rsp_ill",    rsp_illegal, 0);
    chk("rst_alu_a",      alu_a, 0);
    chk("rst_alu_op",     alu_op, 0);
    chk("rst_alu_reset",  alu_reset, 1);

    // Round-robin: both valid continuously, op=0010
    @(posedge clk); #1; reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gid.push_back(req1_ready ? 1 : 0);
        gcyc.push_back(c);
      end
      if (rsp_valid && rsp_ready) rids.push_back(rsp_id);
    end
    chk("rr_grant_count_ge4", gid.size() >= 4, 1);
    chk("rr_resp_count_ge4", rids.size() >= 4, 1);
    if (gid.size() >= 4 && rids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_grant%0d", i), gid[i], i % 2);
        chk($sformatf("rr_rsp_id%0d", i), rids[i], i % 2);
        if (i > 0) chk($sformatf("rr_interval%0d", i), gcyc[i] - gcyc[i-1], 3);
      end
    end
    drain();

    send("add",     1'b0, 4'd7, 4'd5, 4'b0011, 1'b0, 12, 0, 0);
    send("sub_r1",  1'b1, 4'd3, 4'd9, 4'b0010, 1'b0, 10, 1, 0);
    send("illegal", 1'b0, 4'd3, 4'd4, 4'b1110, 1'b0, 0, 0, 1);
    send("op15",    1'b1, 4'd9, 4'd9, 4'b1111, 1'b0, 0, 0, 1);
    send("modzero", 1'b0, 4'd6, 4'd0, 4'b1001, 1'b0, 0, 1, 1);
    send("mod",     1'b1, 4'd7, 4'd3, 4'b1001, 1'b0, 1, 0, 0);
    send("or",      1'b0, 4'd9, 4'd4, 4'b0001, 1'b0, 13, 0, 0);
    drain();

    // Backpressure: hold rsp_ready low 5 cycles in RESP with both valids up
    rsp_ready = 1'b0;
    send("bp", 1'b0, 4'd5, 4'd3, 4'b0100, 1'b0, 6, 0, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 6);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_readys", {req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    drain();

    // Reset during EXEC: no response, rr back to requester 0
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd9; req1_op = 4'd2; req1_acc = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
      if (n >= 20) chk("rstexec_grant_timeout", 0, 1);
    end
    @(posedge clk); #1;               // now in EXEC
    req1_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstexec_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rstexec_rr_req0", req0_ready, 1);
    chk("rstexec_rr_req1", req1_ready, 0);
    drain();

    // Accumulator: reset clears it, then 4+4 and (acc or A=1)+2
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    send("acc1", 1'b0, 4'd4, 4'd4, 4'b0011, 1'b0, 8, 0, 0);
`ifdef ALU_ARB_ACC_EN
    send("acc2", 1'b0, 4'd1, 4'd2, 4'b0011, 1'b1, 10, 0, 0);
`else
    send("acc2", 1'b0, 4'd1, 4'd2, 4'b0011, 1'b1, 3, 0, 0);
`endif
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
